// File: rtl/dmem_request_if.sv
// Datapath-to-memory request bundle: control/ALU inputs in, registered dmem request and retire gating out.
// master is the request unit; slave is the datapath/memory side driving hits, ops and operands.
interface dmem_request_if;
    logic        ihit;
    logic        dhit;
    logic        dren_in;
    logic        dwen_in;
    logic        halt_in;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic        imemREN;
    logic        pc_en;
    logic        dwait;
    logic        halted;
    logic [1:0]  fault_code;

    modport master (
        input  ihit, dhit, dren_in, dwen_in, halt_in, alu_result, store_data,
        output dmemREN, dmemWEN, dmemaddr, dmemstore, imemREN, pc_en, dwait, halted, fault_code
    );

    modport slave (
        output ihit, dhit, dren_in, dwen_in, halt_in, alu_result, store_data,
        input  dmemREN, dmemWEN, dmemaddr, dmemstore, imemREN, pc_en, dwait, halted, fault_code
    );
endinterface

// File: rtl/dmem_request_unit.sv
// Holds one lw/sw request from the issue edge until dhit (REN/WEN 1 cycle after issue, min retire 2 cycles);
// pc_en stalls the PC until fetch and data access complete; faults/halt latch until reset.
module dmem_request_unit #(
    parameter int unsigned TIMEOUT = 200
) (
    input  logic           CLK,
    input  logic           nRST,
    dmem_request_if.master bus
);

    typedef enum logic [1:0] {IDLE, DREQ, HALTED, FAULT} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] cnt;
    logic       req;
    logic       aligned;

    assign req     = bus.dren_in | bus.dwen_in;
    assign aligned = (bus.alu_result[1:0] == 2'b00);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state          <= IDLE;
            cnt            <= 8'd0;
            bus.dmemREN    <= 1'b0;
            bus.dmemWEN    <= 1'b0;
            bus.dmemaddr   <= 32'd0;
            bus.dmemstore  <= 32'd0;
            bus.halted     <= 1'b0;
            bus.fault_code <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.halt_in) begin
                        state      <= HALTED;
                        bus.halted <= 1'b1;
                    end else if (bus.ihit && bus.dren_in && bus.dwen_in) begin
                        state          <= FAULT;
                        bus.fault_code <= 2'b10;
                    end else if (bus.ihit && req && !aligned) begin
                        state          <= FAULT;
                        bus.fault_code <= 2'b01;
                    end else if (bus.ihit && req) begin
                        state         <= DREQ;
                        cnt           <= 8'd0;
                        bus.dmemaddr  <= bus.alu_result;
                        bus.dmemstore <= bus.store_data;
                        bus.dmemREN   <= bus.dren_in;
                        bus.dmemWEN   <= bus.dwen_in;
                    end
                end
                DREQ: begin
                    // dhit takes precedence over an expiring timeout on the same cycle
                    if (bus.dhit) begin
                        state       <= IDLE;
                        bus.dmemREN <= 1'b0;
                        bus.dmemWEN <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state          <= FAULT;
                        bus.fault_code <= 2'b11;
                        bus.dmemREN    <= 1'b0;
                        bus.dmemWEN    <= 1'b0;
                    end else if (cnt != 8'hFF) begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

    assign bus.imemREN = (state == IDLE) || (state == DREQ);
    assign bus.dwait   = (state == DREQ);

    // Gated by nRST so the PC cannot advance while reset is asserted.
    always_comb begin
        bus.pc_en = 1'b0;
        if (nRST) begin
            case (state)
                IDLE:    bus.pc_en = bus.ihit && !req && !bus.halt_in;
                DREQ:    bus.pc_en = bus.dhit;
                default: bus.pc_en = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_request_unit.sv
// Directed bench for dmem_request_unit with TIMEOUT=4: load, store, back-to-back, faults, timeout boundary, halt, async reset.
module tb_dmem_request_unit;

    logic CLK;
    logic nRST;
    int   n_checks = 0;
    int   n_fail   = 0;

    dmem_request_if bus ();

    dmem_request_unit #(.TIMEOUT(4)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus.master)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.ihit       = 1'b0;
        bus.dhit       = 1'b0;
        bus.dren_in    = 1'b0;
        bus.dwen_in    = 1'b0;
        bus.halt_in    = 1'b0;
        bus.alu_result = 32'd0;
        bus.store_data = 32'd0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ren"},   32'(bus.dmemREN),    32'd0);
        chk({tag, "_wen"},   32'(bus.dmemWEN),    32'd0);
        chk({tag, "_addr"},  bus.dmemaddr,        32'd0);
        chk({tag, "_store"}, bus.dmemstore,       32'd0);
        chk({tag, "_imem"},  32'(bus.imemREN),    32'd1);
        chk({tag, "_pcen"},  32'(bus.pc_en),      32'd0);
        chk({tag, "_dwait"}, 32'(bus.dwait),      32'd0);
        chk({tag, "_halt"},  32'(bus.halted),     32'd0);
        chk({tag, "_fault"}, 32'(bus.fault_code), 32'd0);
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        #1;
        tick();
        nRST = 1'b1;
    endtask

    initial begin
        nRST = 1'b1;
        idle_inputs();
        #2;
        // Reset before any edge, with ihit high to prove pc_en is gated
        bus.ihit = 1'b1;
        nRST = 1'b0;
        #1;
        chk_reset_outputs("rst0");
        tick();
        nRST = 1'b1;

        // ALU-only instructions retire every cycle
        for (int c = 0; c < 3; c++) begin
            bus.ihit = 1'b1;
            #1;
            chk("alu_pcen", 32'(bus.pc_en), 32'd1);
            chk("alu_ren",  32'(bus.dmemREN | bus.dmemWEN), 32'd0);
            tick();
        end

        // Load, dhit on third DREQ cycle
        bus.dren_in = 1'b1; bus.alu_result = 32'h0000_0104; bus.ihit = 1'b1;
        #1;
        chk("ld_issue_pcen", 32'(bus.pc_en), 32'd0);
        tick();
        idle_inputs();
        for (int c = 1; c <= 3; c++) begin
            bus.dhit = (c == 3);
            #1;
            chk("ld_ren",   32'(bus.dmemREN), 32'd1);
            chk("ld_addr",  bus.dmemaddr,     32'h0000_0104);
            chk("ld_dwait", 32'(bus.dwait),   32'd1);
            chk("ld_pcen",  32'(bus.pc_en),   (c == 3) ? 32'd1 : 32'd0);
            tick();
        end
        bus.dhit = 1'b0;
        #1;
        chk("ld_after_ren",   32'(bus.dmemREN), 32'd0);
        chk("ld_after_dwait", 32'(bus.dwait),   32'd0);

        // Store with inputs changing during DREQ (including a would-be contradiction)
        bus.dwen_in = 1'b1; bus.alu_result = 32'h0000_0200; bus.store_data = 32'hDEAD_BEEF; bus.ihit = 1'b1;
        tick();
        bus.dwen_in = 1'b0; bus.dren_in = 1'b1; bus.alu_result = 32'h0000_0303;
        bus.store_data = 32'h1234_5678; bus.halt_in = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            bus.dhit = (c == 3);
            #1;
            chk("st_wen",   32'(bus.dmemWEN), 32'd1);
            chk("st_ren",   32'(bus.dmemREN), 32'd0);
            chk("st_addr",  bus.dmemaddr,     32'h0000_0200);
            chk("st_data",  bus.dmemstore,    32'hDEAD_BEEF);
            tick();
        end
        idle_inputs();
        #1;
        chk("st_after_wen",  32'(bus.dmemWEN), 32'd0);
        chk("st_after_halt", 32'(bus.halted),  32'd0);

        // Back-to-back: issue immediately from IDLE after the dhit edge, dhit on 4th DREQ cycle (timeout boundary)
        bus.dren_in = 1'b1; bus.alu_result = 32'h0000_0008; bus.ihit = 1'b1;
        tick();
        idle_inputs();
        for (int c = 1; c <= 4; c++) begin
            bus.dhit = (c == 4);
            #1;
            chk("bnd_ren",  32'(bus.dmemREN), 32'd1);
            chk("bnd_pcen", 32'(bus.pc_en),   (c == 4) ? 32'd1 : 32'd0);
            tick();
        end
        bus.dhit = 1'b0;
        #1;
        chk("bnd_fault", 32'(bus.fault_code), 32'd0);
        chk("bnd_dwait", 32'(bus.dwait),      32'd0);
        chk("bnd_imem",  32'(bus.imemREN),    32'd1);

        // Async reset in the middle of DREQ
        bus.dren_in = 1'b1; bus.alu_result = 32'h0000_0040; bus.ihit = 1'b1;
        tick();
        chk("mid_ren_pre", 32'(bus.dmemREN), 32'd1);
        bus.dhit = 1'b1;
        nRST = 1'b0;
        #1;
        chk_reset_outputs("rst_mid");
        idle_inputs();
        tick();
        nRST = 1'b1;

        // Misaligned load
        bus.dren_in = 1'b1; bus.alu_result = 32'h0000_0102; bus.ihit = 1'b1;
        #1;
        chk("mis_pcen", 32'(bus.pc_en), 32'd0);
        tick();
        idle_inputs();
        #1;
        chk("mis_fault", 32'(bus.fault_code), 32'd1);
        chk("mis_ren",   32'(bus.dmemREN),    32'd0);
        chk("mis_dwait", 32'(bus.dwait),      32'd0);
        chk("mis_imem",  32'(bus.imemREN),    32'd0);
        do_reset();

        // Contradictory load+store
        bus.dren_in = 1'b1; bus.dwen_in = 1'b1; bus.alu_result = 32'h0000_0100; bus.ihit = 1'b1;
        tick();
        idle_inputs();
        #1;
        chk("both_fault", 32'(bus.fault_code), 32'd2);
        chk("both_req",   32'(bus.dmemREN | bus.dmemWEN), 32'd0);
        do_reset();

        // Timeout: 4 DREQ cycles without dhit
        bus.dwen_in = 1'b1; bus.alu_result = 32'h0000_0010; bus.ihit = 1'b1;
        tick();
        idle_inputs();
        for (int c = 1; c <= 3; c++) tick();
        chk("to_pre_dwait", 32'(bus.dwait),      32'd1);
        chk("to_pre_fault", 32'(bus.fault_code), 32'd0);
        tick();
        chk("to_fault", 32'(bus.fault_code), 32'd3);
        chk("to_wen",   32'(bus.dmemWEN),    32'd0);
        chk("to_imem",  32'(bus.imemREN),    32'd0);
        bus.dhit = 1'b1; bus.ihit = 1'b1;
        tick();
        chk("to_hold",  32'(bus.fault_code), 32'd3);
        chk("to_pcen",  32'(bus.pc_en),      32'd0);
        idle_inputs();
        do_reset();

        // Halt without ihit, then held for 10 cycles
        bus.halt_in = 1'b1;
        tick();
        bus.halt_in = 1'b0; bus.ihit = 1'b1;
        #1;
        chk("halt_set",  32'(bus.halted),  32'd1);
        chk("halt_imem", 32'(bus.imemREN), 32'd0);
        chk("halt_pcen", 32'(bus.pc_en),   32'd0);
        for (int c = 0; c < 10; c++) begin
            bus.dren_in = c[0];
            tick();
            chk("halt_hold", 32'(bus.halted),  32'd1);
            chk("halt_pc",   32'(bus.pc_en),   32'd0);
            chk("halt_ren",  32'(bus.dmemREN), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_request_unit.md
# dmem_request_unit

Data-memory request sequencer sitting directly downstream of the ALU in the single-cycle datapath. It takes the ALU result as the effective address for lw/sw, registers and holds the data-memory request until the memory controller answers with `dhit`, and gates PC advance so an instruction retires only once its instruction fetch and any data access have both completed. It also detects misaligned, contradictory and timed-out accesses and latches a halt.

## Interface
- `TIMEOUT`, default 200: maximum DREQ cycles without `dhit` before a timeout fault. Legal range 1..255.
- `CLK` in 1: the single clock; all state updates on the rising edge.
- `nRST` in 1: asynchronous, active-low reset.
- `ihit` in 1: instruction fetch for the current instruction is complete this cycle.
- `dhit` in 1: the outstanding data access completes this cycle.
- `dren_in` in 1: current instruction is a load (from control unit).
- `dwen_in` in 1: current instruction is a store (from control unit).
- `halt_in` in 1: current instruction is halt.
- `alu_result` in 32: effective address produced by the ALU.
- `store_data` in 32: rt register value for stores.
- `dmemREN` out 1: registered data read request.
- `dmemWEN` out 1: registered data write request.
- `dmemaddr` out 32: registered data address.
- `dmemstore` out 32: registered store data.
- `imemREN` out 1: instruction fetch enable.
- `pc_en` out 1: combinational; the PC advances at the next edge when this is 1.
- `dwait` out 1: 1 while in DREQ.
- `halted` out 1: sticky halt indication.
- `fault_code` out 2: sticky fault cause. 00 none, 01 misaligned, 10 both dren and dwen, 11 timeout.

## Operation
- The FSM has four states: IDLE, DREQ, HALTED and FAULT.
- `req` = `dren_in` | `dwen_in`.
- `aligned` = (`alu_result[1:0]` == 2'b00).

IDLE:
- `halt_in`=1 has top priority. Next state is HALTED and `halted` becomes 1.
- Else, if `ihit` & `dren_in` & `dwen_in`: go to FAULT with code 10.
- Else, if `ihit` & `req` & !`aligned`: go to FAULT with code 01. No request is issued.
- Else, if `ihit` & `req` & `aligned`: go to DREQ. At the same edge:
  - latch `dmemaddr`=`alu_result` and `dmemstore`=`store_data`;
  - set `dmemREN`=`dren_in` and `dmemWEN`=`dwen_in`;
  - clear the timeout counter.
- `pc_en` = `ihit` & !`req` & !`halt_in`.
- `dhit` is ignored in IDLE.

DREQ:
- Address, store data and REN/WEN are held constant. Changes on `alu_result`, `store_data`, `dren_in`, `dwen_in` and `halt_in` are ignored.
- `dhit`=1: `pc_en`=1 this cycle. At the edge, clear `dmemREN` and `dmemWEN` and return to IDLE.
- `dhit`=0: the counter increments. If counter == `TIMEOUT`-1, go to FAULT with code 11 and clear REN/WEN at that edge.
- `dhit` on the timeout cycle wins: the access completes normally.

HALTED and FAULT:
- Terminal until reset.
- `pc_en`=0, `imemREN`=0, `dmemREN`=0, `dmemWEN`=0.
- `fault_code` and `halted` are held.

Other rules:
- `imemREN` = 1 in IDLE and DREQ, 0 otherwise.
- The counter is 8 bits and never wraps; it is only meaningful in DREQ.

## Timing
- Reset values, applied asynchronously on `nRST`=0:
  - state IDLE;
  - `dmemREN`=0, `dmemWEN`=0, `dmemaddr`=0, `dmemstore`=0;
  - `halted`=0, `fault_code`=00, counter 0;
  - `imemREN`=1, `pc_en`=0, `dwait`=0.
- Reset mid-DREQ aborts the request immediately and asynchronously.
- Request latency: REN/WEN go high 1 cycle after the IDLE cycle that has `ihit` & `req`.
- Minimum load/store retire: 2 cycles (issue cycle plus a DREQ cycle with `dhit`).
- Back-to-back accesses: after the `dhit` edge, the FSM is in IDLE and can issue again at the next edge. REN/WEN are low for at least 1 cycle between accesses.
- Timeout: FAULT is entered at the edge ending the `TIMEOUT`-th consecutive DREQ cycle with `dhit`=0.

## Test plan
- Reset with `nRST`=0 mid-run, including during DREQ: all outputs at their reset values in the same cycle, before any clock edge.
- ALU-add path: `ihit`=1, no `req`, for 3 cycles -> `pc_en`=1 each cycle, REN/WEN stay 0.
- Load:
  - Stimulus: `dren_in`=1, `alu_result`=0x0000_0104, `ihit`=1, then `dhit`=1 on the third DREQ cycle.
  - Response: `dmemREN`=1 and `dmemaddr`=0x104 for 3 cycles, `pc_en`=1 only on the `dhit` cycle, `dmemREN`=0 afterwards.
- Store with changing inputs:
  - Stimulus: `dwen_in`=1, addr 0x200, `store_data`=0xDEADBEEF; then change `alu_result` and `store_data` during DREQ.
  - Response: `dmemaddr`=0x200 and `dmemstore`=0xDEADBEEF held until `dhit`.
- Faults:
  - Misaligned: addr 0x102 with `dren_in` -> `fault_code`=01, no REN issued.
  - Contradictory: `dren_in`=`dwen_in`=1 -> `fault_code`=10.
  - Timeout: `TIMEOUT`=4 with no `dhit` -> `fault_code`=11 after 4 DREQ cycles.
  - Boundary: `dhit` on the 4th DREQ cycle -> normal completion, no fault.
- Halt: `halt_in`=1 with `ihit`=0 -> `halted`=1 next cycle, `imemREN`=0 and `pc_en`=0, held through 10 further cycles.
